spi_rx_deserializer: RTL and testbench



---
 rtl/spi_rx_deserializer.sv | 69 ++++++
 tb/tb_spi_rx_deserializer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/spi_rx_deserializer.sv
// spi_rx_deserializer: assembles SPI bit events into words on a valid/ready output with overflow and abort pulses.
// Define SPI_RX_LSB_FIRST_EN for LSB-first bit order; MSB first otherwise.
module spi_rx_deserializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs_n,
    input  logic                  bit_evt,
    input  logic                  mosi,
    input  logic                  rx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  overflow,
    output logic                  frame_abort,
    output logic                  busy
);
    localparam int CW = $clog2(DATA_WIDTH);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t                r_state;
    logic [CW-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_shift_en;
    logic                  w_done;
    // Sampling is gated only by cs_n so a bit in the first selected cycle is not lost.
    assign w_shift_en = bit_evt & ~cs_n;
    assign w_done     = w_shift_en && (r_bit_cnt == CW'(DATA_WIDTH - 1));
`ifdef SPI_RX_LSB_FIRST_EN
    assign w_word = {mosi, r_shift[DATA_WIDTH-1:1]};
`else
    assign w_word = {r_shift[DATA_WIDTH-2:0], mosi};
`endif
    assign busy = (r_state == SHIFT);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            overflow    <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            overflow    <= 1'b0;
            frame_abort <= 1'b0;
            r_state     <= cs_n ? IDLE : SHIFT;
            if (cs_n) begin
                frame_abort <= (r_bit_cnt != '0);
                r_bit_cnt   <= '0;
                r_shift     <= '0;
            end else if (w_shift_en) begin
                r_shift   <= w_done ? '0 : w_word;
                r_bit_cnt <= w_done ? '0 : r_bit_cnt + 1'b1;
            end
            // A completed word is dropped only if the pending one is not consumed this cycle.
            if (w_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= w_word;
                    rx_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spi_rx_deserializer.sv
// tb_spi_rx_deserializer: vector table, directed corner sequences and random traffic against a bit-queue model.
module tb_spi_rx_deserializer;
    localparam int DW = 8;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cs_n = 1'b1;
    logic          bit_evt = 1'b0;
    logic          mosi = 1'b0;
    logic          rx_ready = 1'b0;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          overflow;
    logic          frame_abort;
    logic          busy;
    int            n_chk = 0;
    int            n_pass = 0;
    spi_rx_deserializer #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .bit_evt(bit_evt), .mosi(mosi),
        .rx_ready(rx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .overflow(overflow), .frame_abort(frame_abort), .busy(busy)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic c, e, m, r;
        logic v;
        logic [DW-1:0] d;
        logic o, a, b;
    } vec_t;
    vec_t          tbl[$];
    int            m_bits[$];
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ovf, m_abort, m_busy;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask
    task automatic model_reset();
        m_bits.delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_ovf   = 1'b0;
        m_abort = 1'b0;
        m_busy  = 1'b0;
    endtask
    function automatic logic [DW-1:0] pack();
        logic [DW-1:0] w = '0;
        for (int i = 0; i < DW; i++)
`ifdef SPI_RX_LSB_FIRST_EN
            w[i] = m_bits[i][0];
`else
            w[DW-1-i] = m_bits[i][0];
`endif
        return w;
    endfunction
    task automatic cyc(input logic c, input logic e, input logic m, input logic r);
        logic          done;
        logic [DW-1:0] w;
        cs_n = c; bit_evt = e; mosi = m; rx_ready = r;
        done = 1'b0; w = '0;
        m_ovf = 1'b0; m_abort = 1'b0;
        if (c) begin
            m_abort = (m_bits.size() != 0);
            m_bits.delete();
        end else if (e) begin
            m_bits.push_back(int'(m));
            if (m_bits.size() == DW) begin
                done = 1'b1;
                w = pack();
                m_bits.delete();
            end
        end
        if (done) begin
            if (!m_valid || r) begin
                m_data  = w;
                m_valid = 1'b1;
            end else m_ovf = 1'b1;
        end else if (m_valid && r) m_valid = 1'b0;
        m_busy = !c;
        @(posedge clk); #1;
        check("rx_valid", 32'(rx_valid), 32'(m_valid));
        check("rx_data", 32'(rx_data), 32'(m_data));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("frame_abort", 32'(frame_abort), 32'(m_abort));
        check("busy", 32'(busy), 32'(m_busy));
    endtask
    task automatic send_word(input logic [DW-1:0] w, input logic r, input logic r_last);
        for (int i = 0; i < DW; i++)
`ifdef SPI_RX_LSB_FIRST_EN
            cyc(1'b0, 1'b1, w[i], (i == DW - 1) ? r_last : r);
`else
            cyc(1'b0, 1'b1, w[DW-1-i], (i == DW - 1) ? r_last : r);
`endif
    endtask
    task automatic check_zero(input string tag);
        check({tag, " rx_data"}, 32'(rx_data), 32'h0);
        check({tag, " rx_valid"}, 32'(rx_valid), 32'h0);
        check({tag, " overflow"}, 32'(overflow), 32'h0);
        check({tag, " frame_abort"}, 32'(frame_abort), 32'h0);
        check({tag, " busy"}, 32'(busy), 32'h0);
    endtask
    initial begin
        // Palindromic bit pattern gives 0xA5 in either bit order.
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0});
        for (int i = 0; i < 5; i++)
            tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1});
        // cs_n rise with a simultaneous bit_evt: bit ignored, abort still raised.
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0});
        #12;
        check_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            cs_n = tbl[i].c; bit_evt = tbl[i].e; mosi = tbl[i].m; rx_ready = tbl[i].r;
            @(posedge clk); #1;
            check($sformatf("tbl[%0d] rx_valid", i), 32'(rx_valid), 32'(tbl[i].v));
            check($sformatf("tbl[%0d] rx_data", i), 32'(rx_data), 32'(tbl[i].d));
            check($sformatf("tbl[%0d] overflow", i), 32'(overflow), 32'(tbl[i].o));
            check($sformatf("tbl[%0d] frame_abort", i), 32'(frame_abort), 32'(tbl[i].a));
            check($sformatf("tbl[%0d] busy", i), 32'(busy), 32'(tbl[i].b));
        end
        rst_n = 1'b0; #2;
        check_zero("reset2");
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        send_word(8'h3C, 1'b1, 1'b1);
        check("b2b first", 32'(rx_data), 32'h3C);
        send_word(8'hC3, 1'b1, 1'b1);
        check("b2b second", 32'(rx_data), 32'hC3);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        send_word(8'h11, 1'b0, 1'b0);
        send_word(8'h22, 1'b0, 1'b0);
        check("ovf pulse", 32'(overflow), 32'h1);
        check("ovf keep data", 32'(rx_data), 32'h11);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("ovf one cycle", 32'(overflow), 32'h0);
        send_word(8'h22, 1'b0, 1'b1);
        check("simul data", 32'(rx_data), 32'h22);
        check("simul valid", 32'(rx_valid), 32'h1);
        check("simul no ovf", 32'(overflow), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("abort pulse", 32'(frame_abort), 32'h1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        send_word(8'hFF, 1'b0, 1'b0);
        check("after abort", 32'(rx_data), 32'hFF);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0; #2;
        check_zero("midword reset");
        @(posedge clk); #1;
        check_zero("held reset");
        rst_n = 1'b1;
        model_reset();
        send_word(8'h5A, 1'b0, 1'b0);
        check("after reset word", 32'(rx_data), 32'h5A);
        for (int i = 0; i < 600; i++)
            cyc(logic'($urandom_range(0, 15) == 0), logic'($urandom_range(0, 1)),
                logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) == 0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
